// File: rtl/rob_pkg.sv
// rob_pkg: default sizing and shared commit record for the multi-commit reorder buffer
package rob_pkg;
  localparam int ROB_DEPTH = 256;
  localparam int ROB_ALLOC_W = 8;
  localparam int ROB_WB_W = 8;
  localparam int ROB_COMMIT_W = 4;
  localparam int ROB_PHYS_W = 7;
  localparam int ROB_XLEN = 64;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  typedef struct packed {
    logic [ROB_IDX_W-1:0]  idx;
    logic [ROB_PHYS_W-1:0] rd;
    logic [ROB_PHYS_W-1:0] old;
    logic                  is_store;
  } rob_commit_t;
endpackage

// File: rtl/rob_mc_if.sv
// rob_mc_if: rename/writeback/commit signal bundle around the reorder buffer
interface rob_mc_if #(
  parameter int DEPTH = rob_pkg::ROB_DEPTH,
  parameter int ALLOC_W = rob_pkg::ROB_ALLOC_W,
  parameter int WB_W = rob_pkg::ROB_WB_W,
  parameter int COMMIT_W = rob_pkg::ROB_COMMIT_W,
  parameter int PHYS_W = rob_pkg::ROB_PHYS_W,
  parameter int XLEN = rob_pkg::ROB_XLEN
) ();
  localparam int IDX_W = $clog2(DEPTH);
  logic [ALLOC_W-1:0]             alloc_valid_i;
  logic [ALLOC_W-1:0][PHYS_W-1:0] dest_phys_i;
  logic [ALLOC_W-1:0][PHYS_W-1:0] old_dest_phys_i;
  logic [ALLOC_W-1:0]             is_store_i;
  logic [ALLOC_W-1:0]             is_branch_i;
  logic                           alloc_ready_o;
  logic [ALLOC_W-1:0][IDX_W-1:0]  alloc_idx_o;
  logic [WB_W-1:0]                wb_valid_i;
  logic [WB_W-1:0][IDX_W-1:0]     wb_idx_i;
  logic [WB_W-1:0]                wb_branch_misp_i;
  logic [WB_W-1:0][XLEN-1:0]      wb_branch_target_i;
  logic                           commit_ready_i;
  logic [COMMIT_W-1:0]            commit_valid_o;
  logic [COMMIT_W-1:0][IDX_W-1:0] commit_idx_o;
  logic [COMMIT_W-1:0][PHYS_W-1:0] commit_rd_phys_o;
  logic [COMMIT_W-1:0][PHYS_W-1:0] commit_old_phys_o;
  logic [COMMIT_W-1:0]            commit_is_store_o;
  logic                           flush_o;
  logic [XLEN-1:0]                flush_target_o;
  logic [IDX_W:0]                 count_o;
  logic                           empty_o;
  modport slave (
    input  alloc_valid_i, dest_phys_i, old_dest_phys_i, is_store_i, is_branch_i,
    input  wb_valid_i, wb_idx_i, wb_branch_misp_i, wb_branch_target_i, commit_ready_i,
    output alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o, commit_rd_phys_o,
    output commit_old_phys_o, commit_is_store_o, flush_o, flush_target_o, count_o, empty_o
  );
  modport master (
    output alloc_valid_i, dest_phys_i, old_dest_phys_i, is_store_i, is_branch_i,
    output wb_valid_i, wb_idx_i, wb_branch_misp_i, wb_branch_target_i, commit_ready_i,
    input  alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o, commit_rd_phys_o,
    input  commit_old_phys_o, commit_is_store_o, flush_o, flush_target_o, count_o, empty_o
  );
endinterface

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: picks the in-order retiring prefix of the head window
module rob_commit_sel #(
  parameter int COMMIT_W = 4,
  parameter int CW = $clog2(COMMIT_W + 1),
  parameter int LW = COMMIT_W > 1 ? $clog2(COMMIT_W) : 1
) (
  input  logic                commit_ready,
  input  logic [COMMIT_W-1:0] valid,
  input  logic [COMMIT_W-1:0] ready,
  input  logic [COMMIT_W-1:0] is_store,
  input  logic [COMMIT_W-1:0] br_misp,
  output logic [COMMIT_W-1:0] mask,
  output logic [CW-1:0]       ncommit,
  output logic                flush,
  output logic [LW-1:0]       flush_lane
);
  logic go;
  // prefix walk: a lane retires only if all older lanes did; a store or mispredict closes the group
  always_comb begin
    mask = '0;
    ncommit = '0;
    flush = 1'b0;
    flush_lane = '0;
    go = commit_ready;
    for (int n = 0; n < COMMIT_W; n++) begin
      go = go && valid[n] && ready[n];
      mask[n] = go;
      ncommit = ncommit + CW'(go);
      flush_lane = (go && br_misp[n]) ? LW'(n) : flush_lane;
      flush = flush || (go && br_misp[n]);
      go = go && !is_store[n] && !br_misp[n];
    end
  end
endmodule

// File: rtl/rob_mc.sv
// rob_mc: multi-commit reorder buffer with in-order retire and self-generated mispredict flush
module rob_mc import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int ALLOC_W = ROB_ALLOC_W,
  parameter int WB_W = ROB_WB_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int PHYS_W = ROB_PHYS_W,
  parameter int XLEN = ROB_XLEN
) (
  input logic     clk,
  input logic     rst,
  rob_mc_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW = $clog2(COMMIT_W + 1);
  localparam int LW = COMMIT_W > 1 ? $clog2(COMMIT_W) : 1;
  localparam logic [IDX_W:0] MAX_FILL = (IDX_W+1)'(DEPTH - ALLOC_W);
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [PHYS_W-1:0] dest;
    logic [PHYS_W-1:0] old_dest;
    logic              is_store;
    logic              is_branch;
    logic              br_misp;
    logic [XLEN-1:0]   br_tgt;
  } rob_entry_t;
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [PHYS_W-1:0] rd;
    logic [PHYS_W-1:0] old;
    logic              is_store;
  } commit_t;
  rob_entry_t                    ents [DEPTH];
  logic [IDX_W-1:0]              head, tail;
  logic [IDX_W:0]                count, nalloc, nacc;
  logic [ALLOC_W-1:0][IDX_W-1:0] alloc_idx;
  logic                          alloc_ready, alloc_ok;
  logic [COMMIT_W-1:0]           win_valid, win_ready, win_store, win_misp, mask, c_valid;
  logic [CW-1:0]                 ncommit;
  logic                          flush_sel, flush_q;
  logic [LW-1:0]                 flush_lane;
  logic [XLEN-1:0]               flush_tgt_q;
  commit_t                       c_data [COMMIT_W];
  assign alloc_ready = count <= MAX_FILL;
  assign alloc_ok = alloc_ready && !flush_sel;
  assign nacc = alloc_ok ? nalloc : '0;
  // compact valid lanes onto consecutive slots starting at tail
  always_comb begin
    nalloc = '0;
    for (int j = 0; j < ALLOC_W; j++) begin
      alloc_idx[j] = tail + nalloc[IDX_W-1:0];
      nalloc = nalloc + (IDX_W+1)'(bus.alloc_valid_i[j]);
    end
  end
  // head window presented to the selector
  always_comb begin
    for (int n = 0; n < COMMIT_W; n++) begin
      win_valid[n] = ents[head + IDX_W'(n)].valid;
      win_ready[n] = ents[head + IDX_W'(n)].ready;
      win_store[n] = ents[head + IDX_W'(n)].is_store;
      win_misp[n] = ents[head + IDX_W'(n)].br_misp;
    end
  end
  rob_commit_sel #(.COMMIT_W(COMMIT_W), .CW(CW), .LW(LW)) u_sel (
    .commit_ready(bus.commit_ready_i),
    .valid(win_valid),
    .ready(win_ready),
    .is_store(win_store),
    .br_misp(win_misp),
    .mask(mask),
    .ncommit(ncommit),
    .flush(flush_sel),
    .flush_lane(flush_lane)
  );
  // entry array, pointers and registered commit/flush outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      for (int n = 0; n < COMMIT_W; n++) c_data[n] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      c_valid <= '0;
      flush_q <= 1'b0;
      flush_tgt_q <= '0;
    end else begin
      c_valid <= mask;
      for (int n = 0; n < COMMIT_W; n++)
        c_data[n] <= '{idx: head + IDX_W'(n), rd: ents[head + IDX_W'(n)].dest,
                       old: ents[head + IDX_W'(n)].old_dest, is_store: ents[head + IDX_W'(n)].is_store};
      flush_q <= flush_sel;
      flush_tgt_q <= flush_sel ? ents[head + IDX_W'(flush_lane)].br_tgt : '0;
      head <= head + IDX_W'(ncommit);
      if (flush_sel) begin
        for (int i = 0; i < DEPTH; i++) ents[i].valid <= 1'b0;
        tail <= head + IDX_W'(ncommit);
        count <= '0;
      end else begin
        for (int p = 0; p < WB_W; p++)
          if (bus.wb_valid_i[p] && ents[bus.wb_idx_i[p]].valid) begin
            ents[bus.wb_idx_i[p]].ready <= 1'b1;
            ents[bus.wb_idx_i[p]].br_misp <= bus.wb_branch_misp_i[p];
            ents[bus.wb_idx_i[p]].br_tgt <= bus.wb_branch_target_i[p];
          end
        for (int n = 0; n < COMMIT_W; n++)
          if (mask[n]) ents[head + IDX_W'(n)].valid <= 1'b0;
        for (int j = 0; j < ALLOC_W; j++)
          if (alloc_ok && bus.alloc_valid_i[j])
            ents[alloc_idx[j]] <= '{valid: 1'b1, ready: 1'b0, dest: bus.dest_phys_i[j],
                                    old_dest: bus.old_dest_phys_i[j], is_store: bus.is_store_i[j],
                                    is_branch: bus.is_branch_i[j], br_misp: 1'b0, br_tgt: '0};
        tail <= tail + nacc[IDX_W-1:0];
        count <= count + nacc - (IDX_W+1)'(ncommit);
      end
    end
  end
  // drive the bus from registered state
  always_comb begin
    for (int n = 0; n < COMMIT_W; n++) begin
      bus.commit_idx_o[n] = c_data[n].idx;
      bus.commit_rd_phys_o[n] = c_data[n].rd;
      bus.commit_old_phys_o[n] = c_data[n].old;
      bus.commit_is_store_o[n] = c_data[n].is_store;
    end
  end
  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_idx_o = alloc_idx;
  assign bus.commit_valid_o = c_valid;
  assign bus.flush_o = flush_q;
  assign bus.flush_target_o = flush_tgt_q;
  assign bus.count_o = count;
  assign bus.empty_o = count == '0;
endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed scenario checks for the multi-commit reorder buffer
module tb_rob_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  rob_mc_if bus ();
  rob_mc dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.alloc_valid_i = '0;
    bus.dest_phys_i = '0;
    bus.old_dest_phys_i = '0;
    bus.is_store_i = '0;
    bus.is_branch_i = '0;
    bus.wb_valid_i = '0;
    bus.wb_idx_i = '0;
    bus.wb_branch_misp_i = '0;
    bus.wb_branch_target_i = '0;
    bus.commit_ready_i = 1'b0;
  endtask
  task automatic do_reset;
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    do_reset();
    total++; if (bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%0b exp=1", bus.alloc_ready_o); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", bus.empty_o); end
    total++; if (bus.count_o !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.commit_valid_o !== 4'b0) begin bad++; $display("FAIL rst_commit_valid got=%b exp=0000", bus.commit_valid_o); end
    total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b exp=0", bus.flush_o); end
    total++; if (bus.flush_target_o !== 64'h0) begin bad++; $display("FAIL rst_flush_target got=%h exp=0", bus.flush_target_o); end
  endtask
  task automatic test_alloc;
    do_reset();
    bus.alloc_valid_i = 8'b1010_0101;
    #1;
    total++; if (bus.alloc_idx_o[0] !== 8'd0) begin bad++; $display("FAIL alloc_idx0 got=%0d exp=0", bus.alloc_idx_o[0]); end
    total++; if (bus.alloc_idx_o[2] !== 8'd1) begin bad++; $display("FAIL alloc_idx2 got=%0d exp=1", bus.alloc_idx_o[2]); end
    total++; if (bus.alloc_idx_o[5] !== 8'd2) begin bad++; $display("FAIL alloc_idx5 got=%0d exp=2", bus.alloc_idx_o[5]); end
    total++; if (bus.alloc_idx_o[7] !== 8'd3) begin bad++; $display("FAIL alloc_idx7 got=%0d exp=3", bus.alloc_idx_o[7]); end
    step();
    bus.alloc_valid_i = '0;
    #1;
    total++; if (bus.count_o !== 9'd4) begin bad++; $display("FAIL alloc_count got=%0d exp=4", bus.count_o); end
    total++; if (bus.alloc_idx_o[0] !== 8'd4) begin bad++; $display("FAIL alloc_tail got=%0d exp=4", bus.alloc_idx_o[0]); end
  endtask
  task automatic test_fill;
    do_reset();
    bus.alloc_valid_i = 8'hFF;
    repeat (31) step();
    bus.alloc_valid_i = 8'h01;
    step();
    bus.alloc_valid_i = '0;
    total++; if (bus.count_o !== 9'd249) begin bad++; $display("FAIL fill_count got=%0d exp=249", bus.count_o); end
    total++; if (bus.alloc_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", bus.alloc_ready_o); end
    bus.wb_valid_i = 8'h01;
    bus.wb_idx_i[0] = 8'd0;
    step();
    bus.wb_valid_i = '0;
    bus.commit_ready_i = 1'b1;
    #1;
    total++; if (bus.alloc_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready_same_cycle got=%0b exp=0", bus.alloc_ready_o); end
    step();
    bus.commit_ready_i = 1'b0;
    total++; if (bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_after got=%0b exp=1", bus.alloc_ready_o); end
    total++; if (bus.count_o !== 9'd248) begin bad++; $display("FAIL fill_count_after got=%0d exp=248", bus.count_o); end
    total++; if (bus.commit_valid_o !== 4'b0001) begin bad++; $display("FAIL fill_commit got=%b exp=0001", bus.commit_valid_o); end
  endtask
  task automatic test_commit_width;
    do_reset();
    bus.alloc_valid_i = 8'hFF;
    for (int j = 0; j < 8; j++) begin
      bus.dest_phys_i[j] = 7'(10 + j);
      bus.old_dest_phys_i[j] = 7'(20 + j);
    end
    step();
    clear_in();
    bus.wb_valid_i = 8'h3F;
    for (int p = 0; p < 6; p++) bus.wb_idx_i[p] = 8'(p);
    bus.commit_ready_i = 1'b1;
    step();
    bus.wb_valid_i = '0;
    total++; if (bus.commit_valid_o !== 4'b0000) begin bad++; $display("FAIL wb_same_cycle got=%b exp=0000", bus.commit_valid_o); end
    bus.alloc_valid_i = 8'h03;
    step();
    bus.alloc_valid_i = '0;
    total++; if (bus.commit_valid_o !== 4'b1111) begin bad++; $display("FAIL cw_first_valid got=%b exp=1111", bus.commit_valid_o); end
    total++; if (bus.commit_idx_o[0] !== 8'd0 || bus.commit_idx_o[3] !== 8'd3) begin bad++; $display("FAIL cw_first_idx got=%0d,%0d exp=0,3", bus.commit_idx_o[0], bus.commit_idx_o[3]); end
    total++; if (bus.commit_rd_phys_o[2] !== 7'd12) begin bad++; $display("FAIL cw_rd2 got=%0d exp=12", bus.commit_rd_phys_o[2]); end
    total++; if (bus.commit_old_phys_o[3] !== 7'd23) begin bad++; $display("FAIL cw_old3 got=%0d exp=23", bus.commit_old_phys_o[3]); end
    total++; if (bus.count_o !== 9'd6) begin bad++; $display("FAIL cw_count_mixed got=%0d exp=6", bus.count_o); end
    step();
    total++; if (bus.commit_valid_o !== 4'b0011) begin bad++; $display("FAIL cw_second_valid got=%b exp=0011", bus.commit_valid_o); end
    total++; if (bus.commit_idx_o[0] !== 8'd4 || bus.commit_idx_o[1] !== 8'd5) begin bad++; $display("FAIL cw_second_idx got=%0d,%0d exp=4,5", bus.commit_idx_o[0], bus.commit_idx_o[1]); end
    total++; if (bus.count_o !== 9'd4) begin bad++; $display("FAIL cw_count_after got=%0d exp=4", bus.count_o); end
    bus.commit_ready_i = 1'b0;
  endtask
  task automatic test_store;
    do_reset();
    bus.alloc_valid_i = 8'h0F;
    bus.is_store_i = 8'b0000_1010;
    step();
    clear_in();
    bus.wb_valid_i = 8'h0F;
    for (int p = 0; p < 4; p++) bus.wb_idx_i[p] = 8'(p);
    step();
    bus.wb_valid_i = '0;
    bus.commit_ready_i = 1'b1;
    step();
    total++; if (bus.commit_valid_o !== 4'b0011) begin bad++; $display("FAIL st_first_valid got=%b exp=0011", bus.commit_valid_o); end
    total++; if (bus.commit_is_store_o[1:0] !== 2'b10) begin bad++; $display("FAIL st_first_store got=%b exp=10", bus.commit_is_store_o[1:0]); end
    step();
    total++; if (bus.commit_valid_o !== 4'b0011) begin bad++; $display("FAIL st_second_valid got=%b exp=0011", bus.commit_valid_o); end
    total++; if (bus.commit_idx_o[0] !== 8'd2 || bus.commit_idx_o[1] !== 8'd3) begin bad++; $display("FAIL st_second_idx got=%0d,%0d exp=2,3", bus.commit_idx_o[0], bus.commit_idx_o[1]); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL st_empty got=%0b exp=1", bus.empty_o); end
    bus.commit_ready_i = 1'b0;
  endtask
  task automatic test_flush;
    do_reset();
    bus.alloc_valid_i = 8'h0F;
    bus.is_branch_i = 8'b0000_0010;
    step();
    clear_in();
    bus.wb_valid_i = 8'b0010_1111;
    bus.wb_idx_i[0] = 8'd0;
    bus.wb_idx_i[1] = 8'd2;
    bus.wb_idx_i[2] = 8'd1;
    bus.wb_branch_misp_i[2] = 1'b1;
    bus.wb_branch_target_i[2] = 64'hDEAD;
    bus.wb_idx_i[3] = 8'd3;
    bus.wb_idx_i[5] = 8'd1;
    bus.wb_branch_misp_i[5] = 1'b1;
    bus.wb_branch_target_i[5] = 64'h8000_1000;
    step();
    clear_in();
    bus.commit_ready_i = 1'b1;
    bus.alloc_valid_i = 8'hFF;
    step();
    bus.alloc_valid_i = '0;
    total++; if (bus.commit_valid_o !== 4'b0011) begin bad++; $display("FAIL fl_commit got=%b exp=0011", bus.commit_valid_o); end
    total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL fl_pulse got=%0b exp=1", bus.flush_o); end
    total++; if (bus.flush_target_o !== 64'h8000_1000) begin bad++; $display("FAIL fl_target got=%h exp=80001000", bus.flush_target_o); end
    total++; if (bus.count_o !== 9'd0 || bus.empty_o !== 1'b1) begin bad++; $display("FAIL fl_count got=%0d empty=%0b exp=0,1", bus.count_o, bus.empty_o); end
    step();
    total++; if (bus.flush_o !== 1'b0 || bus.commit_valid_o !== 4'b0) begin bad++; $display("FAIL fl_after got=%0b,%b exp=0,0000", bus.flush_o, bus.commit_valid_o); end
    bus.alloc_valid_i = 8'h01;
    #1;
    total++; if (bus.alloc_idx_o[0] !== 8'd2) begin bad++; $display("FAIL fl_tail got=%0d exp=2", bus.alloc_idx_o[0]); end
    clear_in();
  endtask
  task automatic test_wrap;
    do_reset();
    for (int k = 0; k < 127; k++) begin
      bus.alloc_valid_i = 8'h03;
      step();
      bus.alloc_valid_i = '0;
      bus.wb_valid_i = 8'h03;
      bus.wb_idx_i[0] = 8'(2 * k);
      bus.wb_idx_i[1] = 8'(2 * k + 1);
      step();
      bus.wb_valid_i = '0;
      bus.commit_ready_i = 1'b1;
      step();
      bus.commit_ready_i = 1'b0;
    end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL wr_pre_empty got=%0b exp=1", bus.empty_o); end
    bus.alloc_valid_i = 8'h0F;
    #1;
    total++; if (bus.alloc_idx_o[0] !== 8'd254 || bus.alloc_idx_o[1] !== 8'd255) begin bad++; $display("FAIL wr_idx_hi got=%0d,%0d exp=254,255", bus.alloc_idx_o[0], bus.alloc_idx_o[1]); end
    total++; if (bus.alloc_idx_o[2] !== 8'd0 || bus.alloc_idx_o[3] !== 8'd1) begin bad++; $display("FAIL wr_idx_lo got=%0d,%0d exp=0,1", bus.alloc_idx_o[2], bus.alloc_idx_o[3]); end
    step();
    bus.alloc_valid_i = '0;
    total++; if (bus.count_o !== 9'd4) begin bad++; $display("FAIL wr_count got=%0d exp=4", bus.count_o); end
    bus.wb_valid_i = 8'h0F;
    bus.wb_idx_i[0] = 8'd254;
    bus.wb_idx_i[1] = 8'd255;
    bus.wb_idx_i[2] = 8'd0;
    bus.wb_idx_i[3] = 8'd1;
    step();
    bus.wb_valid_i = '0;
    bus.commit_ready_i = 1'b1;
    step();
    bus.commit_ready_i = 1'b0;
    total++; if (bus.commit_valid_o !== 4'b1111) begin bad++; $display("FAIL wr_commit got=%b exp=1111", bus.commit_valid_o); end
    total++; if (bus.commit_idx_o[0] !== 8'd254 || bus.commit_idx_o[3] !== 8'd1) begin bad++; $display("FAIL wr_commit_idx got=%0d,%0d exp=254,1", bus.commit_idx_o[0], bus.commit_idx_o[3]); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL wr_empty got=%0b exp=1", bus.empty_o); end
    bus.alloc_valid_i = 8'h01;
    #1;
    total++; if (bus.alloc_idx_o[0] !== 8'd2) begin bad++; $display("FAIL wr_head got=%0d exp=2", bus.alloc_idx_o[0]); end
    bus.alloc_valid_i = '0;
    rst = 1'b1;
    #1;
    total++; if (bus.commit_valid_o !== 4'b0 || bus.commit_idx_o !== '0) begin bad++; $display("FAIL midrst_commit got=%b,%h exp=0,0", bus.commit_valid_o, bus.commit_idx_o); end
    total++; if (bus.count_o !== 9'd0 || bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_state got=%0d,%0b exp=0,1", bus.count_o, bus.alloc_ready_o); end
    step();
    rst = 1'b0;
  endtask
  initial begin
    clear_in();
    test_reset();
    test_alloc();
    test_fill();
    test_commit_width();
    test_store();
    test_flush();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
